instr_fetch_unit: RTL and testbench

//   Fetch stage directly upstream of the Control_Unit. Holds the PC and fetches
//   one 32-bit instruction over a req/ack instruction-memory handshake.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/next_pc_logic.sv | 38 +++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and field positions for the fetch stage feeding the Control_Unit.
// Instruction encoding is MIPS-like: opcode in the top 6 bits, funct in the bottom 6.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    ERROR
  } fetch_state_t;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int JTYPE_W = 26;
  localparam int IMM_W   = 16;

  // Branch displacement is a signed word offset, so scale by 4 after extending.
  function automatic logic [XLEN-1:0] branch_offset(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W-2){imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC selection from the Control_Unit's flow-control decisions.
// jr beats jump/jal, which beat a taken branch; everything else falls through.
module next_pc_logic
  import cpu_pkg::*;
#(
  parameter int XLEN_P = XLEN
) (
  input  logic [XLEN_P-1:0]  pc_plus4,
  input  logic [JTYPE_W-1:0] jtype_field,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  input  logic               jal,
  input  logic               jr,
  input  logic [XLEN_P-1:0]  jr_target,
  output logic [XLEN_P-1:0]  next_pc,
  output logic               misaligned
);

  logic [XLEN_P-1:0] jump_target;
  logic [XLEN_P-1:0] branch_target;

  assign jump_target   = {pc_plus4[XLEN_P-1:JTYPE_W+2], jtype_field, 2'b00};
  assign branch_target = pc_plus4 + branch_offset(jtype_field[IMM_W-1:0]);

  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = jr_target;
    else if (jump || jal)
      next_pc = jump_target;
    else if (branch && zero)
      next_pc = branch_target;
  end

  assign misaligned = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches one word over req/ack, presents it to the
// Control_Unit and steps the PC when the core retires it. Faults are sticky until reset.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              XLEN_P         = XLEN,
  parameter logic [XLEN_P-1:0] RESET_PC     = RESET_PC_DEFAULT,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [XLEN_P-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [XLEN_P-1:0] pc,
  output logic [XLEN_P-1:0] pc_plus4,
  input  logic              advance,
  input  logic              branch,
  input  logic              zero,
  input  logic              jump,
  input  logic              jal,
  input  logic              jr,
  input  logic [XLEN_P-1:0] jr_target,
  output logic              fetch_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  fetch_state_t      state, state_n;
  logic [XLEN_P-1:0] pc_n;
  logic [31:0]       instr_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              err_n;
  logic [XLEN_P-1:0] next_pc;
  logic              misaligned;

  assign pc_plus4 = pc + XLEN_P'(4);

  next_pc_logic #(.XLEN_P(XLEN_P)) u_next_pc (
    .pc_plus4    (pc_plus4),
    .jtype_field (instr[JTYPE_W-1:0]),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jal         (jal),
    .jr          (jr),
    .jr_target   (jr_target),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      instr     <= NOP_INSTR;
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      instr     <= instr_n;
      cnt       <= cnt_n;
      fetch_err <= err_n;
    end
  end

  // A misaligned target leaves pc on the faulting instruction for debug.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr;
    cnt_n   = cnt;
    err_n   = fetch_err;
    unique case (state)
      FETCH: begin
        if (imem_ack) begin
          instr_n = imem_rdata;
          cnt_n   = '0;
          state_n = ISSUE;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          err_n   = 1'b1;
          state_n = ERROR;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ISSUE: begin
        if (advance) begin
          if (misaligned) begin
            err_n   = 1'b1;
            state_n = ERROR;
          end else begin
            pc_n    = next_pc;
            state_n = FETCH;
          end
        end
      end
      ERROR: err_n = 1'b1;
      default: state_n = ERROR;
    endcase
  end

  assign imem_req    = (state == FETCH) && !rst;
  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);
  assign opcode      = instr[OPC_MSB:OPC_LSB];
  assign funct       = instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: fetch handshake, next-PC
// selection, wrap, misalignment and timeout faults, and reset behaviour.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance, branch, zero, jump, jal, jr;
  logic [31:0] jr_target;
  logic        fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .advance     (advance),
    .branch      (branch),
    .zero        (zero),
    .jump        (jump),
    .jal         (jal),
    .jr          (jr),
    .jr_target   (jr_target),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction word for a single cycle.
  task automatic deliver(input logic [31:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Retire the current instruction with the given control decisions.
  task automatic retire(input logic br, input logic zr, input logic jp,
                        input logic jl, input logic jrr, input logic [31:0] tgt);
    branch = br; zero = zr; jump = jp; jal = jl; jr = jrr; jr_target = tgt;
    advance = 1'b1;
    tick();
    advance = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0;
    jr_target = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_err: got %b want 0", fetch_err); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_instr: got %h want 0", instr); end
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("[TB] FAIL rst_pc: got %h want 0", pc); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("[TB] FAIL req_after_rst: got %b want 1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("[TB] FAIL addr_after_rst: got %h want 0", imem_addr); end
  endtask

  task automatic test_first_fetch();
    tick(); tick(); tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL valid_before_ack: got %b want 0", instr_valid); end
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("[TB] FAIL req_held: got %b want 1", imem_req); end
    deliver(32'h012A_4020);
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL valid_after_ack: got %b want 1", instr_valid); end
    n_cmp++; if (instr !== 32'h012A_4020) begin n_bad++; $display("[TB] FAIL instr_cap: got %h want 012a4020", instr); end
    n_cmp++; if (opcode !== 6'b000000) begin n_bad++; $display("[TB] FAIL opcode: got %b want 000000", opcode); end
    n_cmp++; if (funct !== 6'b100000) begin n_bad++; $display("[TB] FAIL funct: got %b want 100000", funct); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL req_in_issue: got %b want 0", imem_req); end
    // An ack while holding an issued instruction must not overwrite it.
    deliver(32'hFFFF_FFFF);
    n_cmp++; if (instr !== 32'h012A_4020) begin n_bad++; $display("[TB] FAIL issue_ack_ignored: got %h want 012a4020", instr); end
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL valid_hold: got %b want 1", instr_valid); end
  endtask

  task automatic test_sequential_and_branch();
    retire(0, 0, 0, 0, 0, 32'h0);
    n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("[TB] FAIL seq_addr: got %h want 4", imem_addr); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL seq_valid: got %b want 0", instr_valid); end
    tick();
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL valid_wait_ack: got %b want 0", instr_valid); end
    deliver(32'h0000_0020);
    retire(0, 0, 0, 0, 0, 32'h0);
    deliver(32'h1000_FFFF);
    retire(1, 1, 0, 0, 0, 32'h0);
    n_cmp++; if (imem_addr !== 32'h8) begin n_bad++; $display("[TB] FAIL br_taken: got %h want 8", imem_addr); end
    deliver(32'h1000_FFFF);
    retire(1, 0, 0, 0, 0, 32'h0);
    n_cmp++; if (imem_addr !== 32'hC) begin n_bad++; $display("[TB] FAIL br_not_taken: got %h want c", imem_addr); end
  endtask

  task automatic test_jumps();
    deliver(32'h0);
    retire(0, 0, 0, 0, 1, 32'h4000_0010);
    n_cmp++; if (imem_addr !== 32'h4000_0010) begin n_bad++; $display("[TB] FAIL jr_addr: got %h want 40000010", imem_addr); end
    deliver(32'h0C00_0100);
    n_cmp++; if (pc_plus4 !== 32'h4000_0014) begin n_bad++; $display("[TB] FAIL link_val: got %h want 40000014", pc_plus4); end
    retire(0, 0, 0, 1, 0, 32'h0);
    n_cmp++; if (imem_addr !== 32'h4000_0400) begin n_bad++; $display("[TB] FAIL jal_addr: got %h want 40000400", imem_addr); end
    deliver(32'h0800_0123);
    retire(1, 1, 1, 0, 1, 32'h80);
    n_cmp++; if (imem_addr !== 32'h80) begin n_bad++; $display("[TB] FAIL jr_prio: got %h want 80", imem_addr); end
  endtask

  task automatic test_wrap();
    deliver(32'h0);
    retire(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    deliver(32'h0);
    n_cmp++; if (pc_plus4 !== 32'h0) begin n_bad++; $display("[TB] FAIL wrap_plus4: got %h want 0", pc_plus4); end
    retire(0, 0, 0, 0, 0, 32'h0);
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("[TB] FAIL wrap_addr: got %h want 0", imem_addr); end
    n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("[TB] FAIL wrap_no_err: got %b want 0", fetch_err); end
  endtask

  task automatic test_misaligned();
    deliver(32'h0);
    retire(0, 0, 0, 0, 1, 32'h82);
    n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("[TB] FAIL misalign_err: got %b want 1", fetch_err); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL misalign_req: got %b want 0", imem_req); end
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("[TB] FAIL misalign_pc: got %h want 0", pc); end
    deliver(32'h1234_5678);
    tick();
    n_cmp++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_bad++; $display("[TB] FAIL error_sticky: got err=%b req=%b valid=%b want 1/0/0", fetch_err, imem_req, instr_valid);
    end
  endtask

  task automatic test_timeout();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    n_cmp++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
      n_bad++; $display("[TB] FAIL before_timeout: got err=%b req=%b want 0/1", fetch_err, imem_req);
    end
    tick();
    n_cmp++; if (fetch_err !== 1'b1) begin n_bad++; $display("[TB] FAIL timeout_err: got %b want 1", fetch_err); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("[TB] FAIL timeout_req: got %b want 0", imem_req); end
  endtask

  task automatic test_reset_mid_fetch();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    deliver(32'h012A_4020);
    retire(0, 0, 0, 0, 0, 32'h0);
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    tick();
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("[TB] FAIL midrst_instr: got %h want 0", instr); end
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("[TB] FAIL midrst_pc: got %h want 0", pc); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (fetch_err !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_err: got %b want 0", fetch_err); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_bad++; $display("[TB] FAIL midrst_req: got req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
    advance = 1'b0; branch = 1'b0; zero = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0;
    jr_target = 32'h0;
    test_reset();
    test_first_fetch();
    test_sequential_and_branch();
    test_jumps();
    test_wrap();
    test_misaligned();
    test_timeout();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
